shift_add_multiplier: RTL



---
 rtl/mult_pkg.sv | 11 +
 rtl/shift_module.sv | 10 +
 rtl/shift_add_multiplier.sv | 85 ++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier slice.
package mult_pkg;
    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/shift_module.sv
// Combinational 8-bit left shifter controlled by a 3-bit shift amount.
module shift_module
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [CNT_W-1:0] shift,
    output logic [WIDTH-1:0] out
);
    assign out = a << shift;
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier returning the low 8 product bits.
module shift_add_multiplier
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sh;

    shift_module u_shift (
        .a     (a_reg),
        .shift (cnt),
        .out   (sh)
    );

    // Carry out of the adder is dropped; only the low 8 bits of the product are kept.
    assign acc_next = acc + (b_reg[cnt] ? sh : '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == LAST_CNT) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The final accumulate and the product load share the last RUN edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        product <= acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule
